// File: rtl/vec_cache_sram_req_arb.sv
// Request scheduler and read-response buffer in front of one SRAM instance.
// Arbitrates read/write request streams onto the shared SRAM port, captures
// the one-cycle-latency read data into a tagged response FIFO, and promotes
// a starving read over write traffic.

package vec_cache_sram_pkg;
    typedef struct packed {
        logic [8:0] addr;
        logic [1:0] byte_sel;
        logic       mode;
    } sram_inst_cmd_t;
endpackage

module vec_cache_sram_req_arb
    import vec_cache_sram_pkg::*;
#(
    parameter int TAG_W      = 8,
    parameter int STARVE_MAX = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_req_valid,
    output logic                           rd_req_ready,
    input  sram_inst_cmd_t                 rd_req_cmd,
    input  logic [TAG_W-1:0]               rd_req_tag,
    input  logic                           wr_req_valid,
    output logic                           wr_req_ready,
    input  sram_inst_cmd_t                 wr_req_cmd,
    input  logic [31:0]                    wr_req_data,
    output logic                           read_vld,
    output sram_inst_cmd_t                 read_cmd,
    output logic                           write_vld,
    output sram_inst_cmd_t                 write_cmd,
    output logic [31:0]                    wr_data,
    input  logic [31:0]                    rd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_data,
    output logic [TAG_W-1:0]               rsp_tag,
    output logic [$clog2(RSP_DEPTH):0]     rsp_count
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             inflight_q, inflight_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      mem_data_q [RSP_DEPTH];
    logic [TAG_W-1:0] mem_tag_q  [RSP_DEPTH];

    logic [CW:0]      credit_sum;
    logic             rd_credit_ok;
    logic             force_rd;
    logic             push;
    logic             pop;

    // Arbitration and combinational issue onto the SRAM port.
    always_comb begin
        credit_sum   = {1'b0, count_q} + (CW+1)'(inflight_q);
        rd_credit_ok = credit_sum < (CW+1)'(RSP_DEPTH);
        // Forced priority only matters while a read is actually waiting;
        // otherwise a saturated counter would stall writes with nothing to serve.
        force_rd     = rd_req_valid & rd_credit_ok & (starve_cnt_q == 4'(STARVE_MAX));
        wr_req_ready = !rst & !force_rd;
        rd_req_ready = !rst & rd_credit_ok & !(wr_req_valid & !force_rd);
        write_vld    = wr_req_valid & wr_req_ready;
        read_vld     = rd_req_valid & rd_req_ready;
        read_cmd     = rd_req_cmd;
        write_cmd    = wr_req_cmd;
        wr_data      = wr_req_data;
    end

    // Next-state for starvation counter, read pipeline and FIFO bookkeeping.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        inflight_d   = read_vld;
        tag_d        = tag_q;
        push         = inflight_q;
        pop          = (count_q != '0) & rsp_ready;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (read_vld) begin
            starve_cnt_d = 4'd0;
            tag_d        = rd_req_tag;
        end else if (rd_req_valid & rd_credit_ok & write_vld &
                     (starve_cnt_q != 4'(STARVE_MAX))) begin
            // Only a read that lost to a write counts; lack of credit does not.
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; an in-flight read is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            inflight_q   <= 1'b0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            inflight_q   <= inflight_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Response storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data_q[wr_ptr_q] <= rd_data;
            mem_tag_q[wr_ptr_q]  <= tag_q;
        end
    end

    // Head-of-FIFO response, forced to zero while empty.
    always_comb begin
        rsp_valid = (count_q != '0);
        rsp_count = count_q;
        rsp_data  = rsp_valid ? mem_data_q[rd_ptr_q] : 32'd0;
        rsp_tag   = rsp_valid ? mem_tag_q[rd_ptr_q]  : '0;
    end

`ifndef SYNTHESIS
    // The credit check must make a push into a full FIFO unreachable.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (count_q != CW'(RSP_DEPTH))
            else $error("response FIFO push while full");
        end
    end
`endif

endmodule
